// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures wave_in rise-to-rise period and maps it to a note index 1..21.
// Optional TONE_DECODER_CONFIRM_EN: require two consecutive equal decodes before asserting note_valid.
module tone_decoder #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TIMEOUT = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wave_in,
  output logic [4:0]  note,
  output logic        note_valid,
  output logic        new_note,
  output logic [31:0] period
);

  localparam logic [31:0] TO = 32'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRACK} state_t;

  function automatic int note_hz(input int idx);
    case (idx)
      1:  return 262;   2:  return 294;   3:  return 330;   4:  return 349;
      5:  return 392;   6:  return 440;   7:  return 494;   8:  return 523;
      9:  return 587;   10: return 659;   11: return 699;   12: return 784;
      13: return 880;   14: return 988;   15: return 1050;  16: return 1175;
      17: return 1319;  18: return 1397;  19: return 1568;  20: return 1760;
      21: return 1976;
      default: return 1;
    endcase
  endfunction

  state_t      r_state;
  logic [2:0]  r_sync;
  logic [31:0] r_cnt;
  logic [31:0] r_period;
  logic        r_upd;
  logic [4:0]  r_note;
  logic        r_valid;
  logic        r_new;
  logic        w_rise;
  logic [21:1] w_hit;
  logic [4:0]  w_idx;
  logic        w_ok;
  logic        w_chg;

  assign w_rise = r_sync[1] & ~r_sync[2];

  // One window comparator per note; nominal and tolerance fold to constants.
  for (genvar i = 1; i <= 21; i++) begin : g_note
    localparam logic [31:0] NOM = 32'(CLK_HZ / note_hz(i));
    localparam logic [31:0] TOL = NOM >> 6;
    logic [31:0] w_diff;
    assign w_diff   = (r_period >= NOM) ? (r_period - NOM) : (NOM - r_period);
    assign w_hit[i] = (w_diff <= TOL);
  end

  always_comb begin
    w_idx = '0;
    for (int i = 21; i >= 1; i--)
      if (w_hit[i]) w_idx = 5'(i);
  end

`ifdef TONE_DECODER_CONFIRM_EN
  logic [4:0] r_last;
  assign w_ok = (w_idx != '0) && (w_idx == r_last);
`else
  assign w_ok = (w_idx != '0);
`endif

  assign w_chg = w_ok && (!r_valid || (w_idx != r_note));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sync   <= '0;
      r_cnt    <= '0;
      r_period <= '0;
      r_upd    <= 1'b0;
      r_note   <= '0;
      r_valid  <= 1'b0;
      r_new    <= 1'b0;
`ifdef TONE_DECODER_CONFIRM_EN
      r_last   <= '0;
`endif
    end else begin
      r_sync <= {r_sync[1:0], wave_in};
      r_upd  <= 1'b0;
      r_new  <= 1'b0;

      if (w_rise)        r_cnt <= 32'd1;
      else if (r_cnt < TO) r_cnt <= r_cnt + 32'd1;

      // A rise takes priority over a timeout in the same cycle.
      case (r_state)
        S_IDLE: if (w_rise) r_state <= S_ARMED;
        default: begin
          if (w_rise) begin
            r_period <= r_cnt;
            r_upd    <= 1'b1;
            r_state  <= S_TRACK;
          end else if (r_cnt >= TO) begin
            r_state  <= S_IDLE;
            r_period <= '0;
            r_note   <= '0;
            r_valid  <= 1'b0;
`ifdef TONE_DECODER_CONFIRM_EN
            r_last   <= '0;
`endif
          end
        end
      endcase

      if (r_upd) begin
        r_note  <= w_ok ? w_idx : 5'd0;
        r_valid <= w_ok;
        r_new   <= w_chg;
`ifdef TONE_DECODER_CONFIRM_EN
        r_last  <= w_idx;
`endif
      end
    end
  end

  assign note       = r_note;
  assign note_valid = r_valid;
  assign new_note   = r_new;
  assign period     = r_period;

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder: directed tones push expected output events, a monitor pops and compares.
module tb_tone_decoder;

  localparam int CLK_HZ  = 2_000_000;
  localparam int TIMEOUT = 5000;
  localparam int P13 = 2272;  // 2e6/880
  localparam int P17 = 1516;  // 2e6/1319
  localparam int PU  = 2150;  // between notes 13 and 14 windows
`ifdef TONE_DECODER_CONFIRM_EN
  localparam bit CONF = 1'b1;
`else
  localparam bit CONF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wave_in = 1'b0;
  logic [4:0]  note;
  logic        note_valid;
  logic        new_note;
  logic [31:0] period;

  int cyc = 0;
  int chk = 0;
  int err = 0;

  typedef struct {
    logic [4:0]  note;
    logic        v;
    logic [31:0] per;
    logic        nn;
    int          cyc;
  } ev_t;
  ev_t q[$];

  logic [4:0]  m_note = '0;
  logic        m_v    = 1'b0;
  logic [31:0] m_per  = '0;

  tone_decoder #(.CLK_HZ(CLK_HZ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wave_in(wave_in),
    .note(note), .note_valid(note_valid), .new_note(new_note), .period(period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any visible output change or new_note pulse must match the next expected event.
  logic [4:0]  p_note = '0;
  logic        p_v    = 1'b0;
  logic [31:0] p_per  = '0;
  always @(negedge clk) begin
    if (note !== p_note || note_valid !== p_v || period !== p_per || new_note !== 1'b0) begin
      chk++;
      if (q.size() == 0) begin
        err++;
        $display("FAIL unexpected_event: got note=%0d v=%0d per=%0d nn=%0d at cyc=%0d, want no change",
                 note, note_valid, period, new_note, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (note !== e.note || note_valid !== e.v || period !== e.per || new_note !== e.nn || cyc != e.cyc) begin
          err++;
          $display("FAIL event: got note=%0d v=%0d per=%0d nn=%0d cyc=%0d, want note=%0d v=%0d per=%0d nn=%0d cyc=%0d",
                   note, note_valid, period, new_note, cyc, e.note, e.v, e.per, e.nn, e.cyc);
        end
      end
    end
    p_note = note; p_v = note_valid; p_per = period;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [4:0] n, input logic v, input logic [31:0] p, input logic nn, input int c);
    ev_t e;
    e.note = n; e.v = v; e.per = p; e.nn = nn; e.cyc = c;
    q.push_back(e);
    m_note = n; m_v = v; m_per = p;
  endtask

  // One rise, then 'hold' cycles until the next one. Period shows 3 cycles after the drive, decode 1 later.
  task automatic rise(input int hold, input logic pev, input logic [31:0] pval,
                      input logic nev, input logic [4:0] n, input logic v, input logic nn, input logic tev);
    int c;
    c = cyc;
    wave_in = 1'b1;
    if (pev) push(m_note, m_v, pval, 1'b0, c + 3);
    if (nev) push(n, v, m_per, nn, c + 4);
    if (tev) push(5'd0, 1'b0, 32'd0, 1'b0, c + 3 + TIMEOUT);
    step(hold / 2);
    wave_in = 1'b0;
    step(hold - hold / 2);
  endtask

  task automatic do_rst();
    int c;
    c = cyc;
    rst = 1'b1;
    push(5'd0, 1'b0, 32'd0, 1'b0, c + 1);
    step(3);
    rst = 1'b0;
    step(50);
  endtask

  task automatic zero_check(input string name);
    chk++;
    if (note !== 5'd0 || note_valid !== 1'b0 || new_note !== 1'b0 || period !== 32'd0) begin
      err++;
      $display("FAIL %s: got note=%0d v=%0d nn=%0d per=%0d, want all 0", name, note, note_valid, new_note, period);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      zero_check("reset_hold");
      wave_in = ~wave_in;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wave_in = 1'b0;
    step(1);
    @(negedge clk);
    zero_check("post_release");
    step(1);

    // Note 13 tone: matched after rise 2 (or rise 3 when confirming).
    rise(P13, 1'b0, 0,    1'b0,  5'd0,  1'b0, 1'b0, 1'b0);
    rise(P13, 1'b1, P13,  !CONF, 5'd13, 1'b1, 1'b1, 1'b0);
    rise(P13, 1'b0, 0,    CONF,  5'd13, 1'b1, 1'b1, 1'b0);
    rise(P13, 1'b0, 0,    1'b0,  5'd0,  1'b0, 1'b0, 1'b0);
    rise(P17, 1'b0, 0,    1'b0,  5'd0,  1'b0, 1'b0, 1'b0);
    // Change to note 17.
    rise(P17, 1'b1, P17,  1'b1,  CONF ? 5'd0 : 5'd17, !CONF, !CONF, 1'b0);
    rise(P17, 1'b0, 0,    CONF,  5'd17, 1'b1, 1'b1, 1'b0);
    rise(PU,  1'b0, 0,    1'b0,  5'd0,  1'b0, 1'b0, 1'b0);
    // Unmatched period drops the note without a pulse.
    rise(PU,  1'b1, PU,   1'b1,  5'd0,  1'b0, 1'b0, 1'b0);
    // Hold low past the timeout.
    rise(TIMEOUT + 200, 1'b0, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    // Next rise only arms.
    rise(P13, 1'b0, 0,    1'b0,  5'd0,  1'b0, 1'b0, 1'b0);
    rise(1500, 1'b1, P13, !CONF, 5'd13, 1'b1, 1'b1, 1'b0);
    // Reset midway through a period.
    do_rst();
    rise(P13, 1'b0, 0,    1'b0,  5'd0,  1'b0, 1'b0, 1'b0);
    rise(P13, 1'b1, P13,  !CONF, 5'd13, 1'b1, 1'b1, 1'b0);
    step(20);

    chk++;
    if (q.size() != 0) begin
      err++;
      $display("FAIL pending_events: got %0d outstanding, want 0 (next want per=%0d cyc=%0d)",
               q.size(), q[0].per, q[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
